// File: rtl/mips_pkg.sv
// Shared definitions for the MEM stage: access-size encoding, FSM state
// encoding, byte-enable constants and small lane helpers.
package mips_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HALF  = 2'd1,
    SIZE_WORD  = 2'd2,
    SIZE_WORD3 = 2'd3
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Encoding 3 is an alias for a word access.
  function automatic mem_size_e norm_size(input logic [1:0] s);
    return (s == 2'd3) ? SIZE_WORD : mem_size_e'(s);
  endfunction

  function automatic logic [3:0] byte_enable(input mem_size_e s, input logic [1:0] a);
    case (s)
      SIZE_BYTE: return BE_BYTE << a;
      SIZE_HALF: return BE_HALF << {a[1], 1'b0};
      default:   return BE_WORD;
    endcase
  endfunction

  // Stores place the same data on every lane; byte enables pick the lane.
  function automatic logic [31:0] replicate(input mem_size_e s, input logic [31:0] d);
    case (s)
      SIZE_BYTE: return {4{d[7:0]}};
      SIZE_HALF: return {2{d[15:0]}};
      default:   return d;
    endcase
  endfunction

  function automatic logic misaligned(input mem_size_e s, input logic [1:0] a);
    case (s)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return a[0];
      default:   return (a != 2'b00);
    endcase
  endfunction

  // Forces the low address bits down to the natural alignment of the size.
  function automatic logic [1:0] align_lo(input mem_size_e s, input logic [1:0] a);
    case (s)
      SIZE_BYTE: return a;
      SIZE_HALF: return {a[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane selection (little-endian) and zero/sign extension.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        load_signed,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed lane, then extend it to 32 bits.
  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    data      = rdata;
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (norm_size(size))
      SIZE_BYTE: data = {{24{load_signed & byte_lane[7]}}, byte_lane};
      SIZE_HALF: data = {{16{load_signed & half_lane[15]}}, half_lane};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results through in one cycle and runs
// loads/stores over a valid/ready-style bus with an IDLE/BUSY FSM.
// Optional build macro: MEM_ALIGN_CHECK_EN -- misaligned half/word accesses
// are trapped (misalign pulse, no bus cycle) instead of being aligned down.
//
// Handshake: once BUSY, bus_req stays high and bus_addr/bus_we/bus_wdata/
// bus_be are frozen until a rising edge samples bus_ready=1; that edge
// retires the op. stall mirrors BUSY, and upstream holds its inputs while
// stall is high, so in_valid is not looked at in BUSY.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              load_signed,
  input  logic [4:0]        rd_in,
  input  logic              reg_write_in,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic              misalign,
  output logic              dbg_state
);

  mem_state_e state_q, state_d;

  logic        mem_op;
  logic        alu_op;
  logic        start;
  logic        fault;
  logic        retire;
  logic        misalign_in;
  mem_size_e   size_in;
  logic [1:0]  addr_lo_in;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [4:0]        rd_q;
  logic              rw_q;
  logic              misalign_q;
  logic [31:0]       load_data;

  assign mem_op     = in_valid & (mem_read | mem_write);
  assign alu_op     = in_valid & ~(mem_read | mem_write);
  assign size_in    = norm_size(mem_size);
  assign addr_lo_in = align_lo(size_in, alu_result[1:0]);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_in = misaligned(size_in, alu_result[1:0]);
`else
  assign misalign_in = 1'b0;
`endif

  // Next-state and per-cycle event decode.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    fault   = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          if (misalign_in) begin
            fault = 1'b1;
          end else begin
            start   = 1'b1;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (bus_ready) begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Latch the memory op at issue; these registers drive the bus while BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      wdata_q  <= '0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      rd_q     <= 5'd0;
      rw_q     <= 1'b0;
    end else if (start) begin
      addr_q   <= {alu_result[ADDR_W-1:2], addr_lo_in};
      we_q     <= mem_write;
      be_q     <= byte_enable(size_in, addr_lo_in);
      wdata_q  <= replicate(size_in, store_data);
      size_q   <= size_in;
      signed_q <= load_signed;
      rd_q     <= rd_in;
      rw_q     <= reg_write_in;
    end
  end

  load_align u_load_align (
    .rdata       (bus_rdata),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .load_signed (signed_q),
    .data        (load_data)
  );

  // Writeback register: one-cycle wb_valid pulse per retired op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      misalign_q   <= 1'b0;
      if (state_q == ST_IDLE && alu_op) begin
        wb_valid     <= 1'b1;
        wb_data      <= alu_result;
        wb_rd        <= rd_in;
        wb_reg_write <= reg_write_in;
      end else if (fault) begin
        wb_valid     <= 1'b1;
        wb_data      <= alu_result;
        wb_rd        <= rd_in;
        misalign_q   <= 1'b1;
      end else if (retire) begin
        wb_valid     <= 1'b1;
        wb_data      <= we_q ? '0 : load_data;
        wb_rd        <= rd_q;
        wb_reg_write <= rw_q & ~we_q;
      end
    end
  end

  assign stall     = (state_q == ST_BUSY);
  assign bus_req   = (state_q == ST_BUSY);
  assign bus_we    = we_q & (state_q == ST_BUSY);
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign misalign  = misalign_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single ops with hand-computed
// results, then hand-written multi-cycle sequences (wait states, misaligned
// word, reset mid-transaction, back-to-back zero-wait loads).
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        load_signed;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        misalign;
  logic        dbg_state;

  int n_vec;
  int n_fail;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sdata;
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  size;
    logic        sgn;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[12];

  mem_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .load_signed  (load_signed),
    .rd_in        (rd_in),
    .reg_write_in (reg_write_in),
    .stall        (stall),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_be       (bus_be),
    .bus_ready    (bus_ready),
    .bus_rdata    (bus_rdata),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .misalign     (misalign),
    .dbg_state    (dbg_state)
  );

  // Clock: active edge is posedge; the bench drives and samples on negedge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_op(input logic [31:0] alu, input logic [31:0] sdata, input logic rd_en,
                          input logic wr_en, input logic [1:0] size, input logic sgn,
                          input logic [4:0] rd, input logic rw);
    in_valid     = 1'b1;
    alu_result   = alu;
    store_data   = sdata;
    mem_read     = rd_en;
    mem_write    = wr_en;
    mem_size     = size;
    load_signed  = sgn;
    rd_in        = rd;
    reg_write_in = rw;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // One table row: issue, check the bus side (memory ops), then the writeback.
  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    drive_op(v.alu, v.sdata, v.rd_en, v.wr_en, v.size, v.sgn, v.rd, v.rw);
    tick();
    if (v.rd_en | v.wr_en) begin
      check($sformatf("v%0d wb_valid_issue", i), {31'd0, wb_valid}, 32'd0);
      check($sformatf("v%0d stall", i), {31'd0, stall}, 32'd1);
      check($sformatf("v%0d bus_req", i), {31'd0, bus_req}, 32'd1);
      check($sformatf("v%0d bus_we", i), {31'd0, bus_we}, {31'd0, v.wr_en});
      check($sformatf("v%0d bus_addr", i), bus_addr, v.exp_addr);
      check($sformatf("v%0d bus_be", i), {28'd0, bus_be}, {28'd0, v.exp_be});
      check($sformatf("v%0d bus_wdata", i), bus_wdata, v.exp_wdata);
      idle_inputs();
      bus_ready = 1'b1;
      bus_rdata = v.rdata;
      tick();
      bus_ready = 1'b0;
    end else begin
      idle_inputs();
      check($sformatf("v%0d bus_req", i), {31'd0, bus_req}, 32'd0);
    end
    check($sformatf("v%0d wb_valid", i), {31'd0, wb_valid}, 32'd1);
    check($sformatf("v%0d wb_data", i), wb_data, v.exp_wb);
    check($sformatf("v%0d wb_rd", i), {27'd0, wb_rd}, {27'd0, v.rd});
    check($sformatf("v%0d wb_reg_write", i), {31'd0, wb_reg_write}, {31'd0, v.exp_rw});
    check($sformatf("v%0d stall_after", i), {31'd0, stall}, 32'd0);
    tick();
    check($sformatf("v%0d wb_pulse", i), {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    //          alu           sdata         rd wr sz sg rd     rw rdata         addr          be       wdata         wb            rw
    vecs[0]  = '{32'h00001234, 32'h0,       0, 0, 2, 0, 5'd5,  1, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h00001234, 1};
    vecs[1]  = '{32'hDEADBEEF, 32'h0,       0, 0, 2, 0, 5'd31, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hDEADBEEF, 0};
    vecs[2]  = '{32'h00000100, 32'h0,       1, 0, 0, 0, 5'd3,  1, 32'h11223384, 32'h00000100, 4'b0001, 32'h0,        32'h00000084, 1};
    vecs[3]  = '{32'h00000101, 32'h0,       1, 0, 0, 1, 5'd4,  1, 32'h1122F033, 32'h00000101, 4'b0010, 32'h0,        32'hFFFFFFF0, 1};
    vecs[4]  = '{32'h00000102, 32'h0,       1, 0, 1, 1, 5'd6,  1, 32'h9ABC0000, 32'h00000102, 4'b1100, 32'h0,        32'hFFFF9ABC, 1};
    vecs[5]  = '{32'h00000100, 32'h0,       1, 0, 1, 0, 5'd7,  1, 32'hFFFF8001, 32'h00000100, 4'b0011, 32'h0,        32'h00008001, 1};
    vecs[6]  = '{32'h0000010C, 32'h0,       1, 0, 2, 0, 5'd8,  1, 32'hCAFEF00D, 32'h0000010C, 4'b1111, 32'h0,        32'hCAFEF00D, 1};
    vecs[7]  = '{32'h00000110, 32'h0,       1, 0, 3, 1, 5'd9,  1, 32'h12345678, 32'h00000110, 4'b1111, 32'h0,        32'h12345678, 1};
    vecs[8]  = '{32'h00000102, 32'h0,       1, 0, 0, 1, 5'd10, 1, 32'h007F0000, 32'h00000102, 4'b0100, 32'h0,        32'h0000007F, 1};
    vecs[9]  = '{32'h00000301, 32'h000000A5, 0, 1, 0, 0, 5'd11, 1, 32'h0,       32'h00000301, 4'b0010, 32'hA5A5A5A5, 32'h0,        0};
    vecs[10] = '{32'h00000202, 32'h1234ABCD, 0, 1, 1, 0, 5'd12, 1, 32'h0,       32'h00000202, 4'b1100, 32'hABCDABCD, 32'h0,        0};
    vecs[11] = '{32'h00000400, 32'h87654321, 0, 1, 2, 0, 5'd13, 1, 32'h0,       32'h00000400, 4'b1111, 32'h87654321, 32'h0,        0};

    // Reset block: inputs quiet, check values while reset is asserted.
    rst_n     = 1'b0;
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
    drive_op(32'h0, 32'h0, 0, 0, 2'd0, 0, 5'd0, 0);
    idle_inputs();
    #2;
    check("rst stall", {31'd0, stall}, 32'd0);
    check("rst bus_req", {31'd0, bus_req}, 32'd0);
    check("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    check("rst misalign", {31'd0, misalign}, 32'd0);
    check("rst wb_data", wb_data, 32'd0);
    check("rst bus_addr", bus_addr, 32'd0);
    check("rst bus_be", {28'd0, bus_be}, 32'd0);
    check("rst state", {31'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_vec(i);

    // lb signed at 0x103 with three BUSY cycles before the bus answers.
    drive_op(32'h00000103, 32'h0, 1, 0, 2'd0, 1, 5'd9, 1);
    bus_rdata = 32'h80FFFFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      idle_inputs();
      check($sformatf("lb_wait stall c%0d", c), {31'd0, stall}, 32'd1);
      check($sformatf("lb_wait wb_valid c%0d", c), {31'd0, wb_valid}, 32'd0);
      check($sformatf("lb_wait bus_addr c%0d", c), bus_addr, 32'h00000103);
    end
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    check("lb_wait wb_valid", {31'd0, wb_valid}, 32'd1);
    check("lb_wait wb_data", wb_data, 32'hFFFFFF80);
    check("lb_wait stall_after", {31'd0, stall}, 32'd0);
    tick();

    // lw at 0x005: trapped with the check enabled, aligned down otherwise.
    drive_op(32'h00000005, 32'h0, 1, 0, 2'd2, 0, 5'd14, 1);
    tick();
    idle_inputs();
`ifdef MEM_ALIGN_CHECK_EN
    check("mis misalign", {31'd0, misalign}, 32'd1);
    check("mis wb_valid", {31'd0, wb_valid}, 32'd1);
    check("mis wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    check("mis bus_req", {31'd0, bus_req}, 32'd0);
    check("mis stall", {31'd0, stall}, 32'd0);
    tick();
    check("mis misalign_pulse", {31'd0, misalign}, 32'd0);
    check("mis wb_pulse", {31'd0, wb_valid}, 32'd0);
    check("mis bus_req_after", {31'd0, bus_req}, 32'd0);
`else
    check("mis bus_req", {31'd0, bus_req}, 32'd1);
    check("mis bus_addr", bus_addr, 32'h00000004);
    check("mis bus_be", {28'd0, bus_be}, 32'hF);
    bus_ready = 1'b1;
    bus_rdata = 32'h5A5A5A5A;
    tick();
    bus_ready = 1'b0;
    check("mis wb_valid", {31'd0, wb_valid}, 32'd1);
    check("mis wb_data", wb_data, 32'h5A5A5A5A);
    check("mis misalign", {31'd0, misalign}, 32'd0);
    tick();
`endif

    // Reset in the middle of a BUSY load; a late bus_ready must be ignored.
    drive_op(32'h00000040, 32'h0, 1, 0, 2'd2, 0, 5'd15, 1);
    tick();
    idle_inputs();
    check("rbusy stall", {31'd0, stall}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rbusy stall_rst", {31'd0, stall}, 32'd0);
    check("rbusy bus_req_rst", {31'd0, bus_req}, 32'd0);
    check("rbusy state_rst", {31'd0, dbg_state}, 32'd0);
    check("rbusy bus_addr_rst", bus_addr, 32'd0);
    bus_ready = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("rbusy wb_valid c%0d", c), {31'd0, wb_valid}, 32'd0);
      check($sformatf("rbusy state c%0d", c), {31'd0, dbg_state}, 32'd0);
    end
    bus_ready = 1'b0;
    tick();

    // Back-to-back zero-wait loads: writebacks exactly two cycles apart.
    bus_ready = 1'b1;
    bus_rdata = 32'h11111111;
    drive_op(32'h00000080, 32'h0, 1, 0, 2'd2, 0, 5'd7, 1);
    tick();
    check("b2b c1 wb_valid", {31'd0, wb_valid}, 32'd0);
    check("b2b c1 stall", {31'd0, stall}, 32'd1);
    tick();
    check("b2b c2 wb_valid", {31'd0, wb_valid}, 32'd1);
    check("b2b c2 wb_data", wb_data, 32'h11111111);
    check("b2b c2 wb_rd", {27'd0, wb_rd}, 32'd7);
    drive_op(32'h00000084, 32'h0, 1, 0, 2'd2, 0, 5'd8, 1);
    bus_rdata = 32'h22222222;
    tick();
    idle_inputs();
    check("b2b c3 wb_valid", {31'd0, wb_valid}, 32'd0);
    check("b2b c3 bus_addr", bus_addr, 32'h00000084);
    tick();
    check("b2b c4 wb_valid", {31'd0, wb_valid}, 32'd1);
    check("b2b c4 wb_data", wb_data, 32'h22222222);
    check("b2b c4 wb_rd", {27'd0, wb_rd}, 32'd8);
    bus_ready = 1'b0;
    tick();
    check("b2b c5 wb_valid", {31'd0, wb_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
- REQ-001 SHALL have parameter DATA_W, default 32: datapath and bus data width; only 32 is supported.
- REQ-002 SHALL have parameter ADDR_W, default 32: memory address width.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
- REQ-005 SHALL have in_valid, input, 1 bit: an EX result is presented.
- REQ-006 SHALL have alu_result, input, 32 bits: effective address, or the writeback value for non-memory ops.
- REQ-007 SHALL have store_data, input, 32 bits: forwarded rt value for stores.
- REQ-008 SHALL have mem_read and mem_write, inputs, 1 bit each; both high at once is illegal.
- REQ-009 SHALL have mem_size, input, 2 bits: 0=byte, 1=half, 2=word.
- REQ-010 SHALL have load_signed, input, 1 bit; rd_in, input, 5 bits; reg_write_in, input, 1 bit.
- REQ-011 SHALL have stall, output, 1 bit: upstream holds all inputs stable while high.
- REQ-012 SHALL have bus ports bus_req (out, 1), bus_we (out, 1), bus_addr (out, ADDR_W), bus_wdata (out, 32), bus_be (out, 4), bus_ready (in, 1) and bus_rdata (in, 32).
- REQ-013 SHALL have outputs wb_valid (1), wb_data (32), wb_rd (5), wb_reg_write (1) and misalign (1).

Function
- REQ-014 SHALL implement FSM IDLE/BUSY; a memory op is in_valid & (mem_read | mem_write).
- REQ-015 In IDLE, a non-memory op SHALL produce wb_valid=1 on the next edge, with wb_data=alu_result, wb_rd=rd_in and wb_reg_write=reg_write_in (latency 1).
- REQ-016 In IDLE, a memory op SHALL latch address, size, data and control, then enter BUSY; no wb_valid is produced that cycle.
- REQ-017 In BUSY, bus_req SHALL be 1 and bus_addr, bus_we, bus_wdata and bus_be SHALL be held stable until bus_ready.
- REQ-018 stall SHALL equal (state==BUSY); in_valid SHALL be ignored while in BUSY.
- REQ-019 When bus_ready=1 in BUSY, the next edge SHALL set wb_valid=1 and return the FSM to IDLE, giving a minimum memory-op occupancy of 2 cycles.
- REQ-020 A load SHALL select the little-endian lane by addr[1:0] (half: addr[1]), then zero- or sign-extend it per load_signed.
- REQ-021 A store SHALL set bus_be to 0001<<addr[1:0] (byte), 0011<<{addr[1],0} (half) or 1111 (word), with wdata replicated across lanes.
- REQ-022 A store's writeback SHALL have wb_reg_write=0; wb_valid SHALL be a 1-cycle pulse per retired op.
- REQ-023 mem_size=3 SHALL be treated as word.

Reset
- REQ-024 rst_n low SHALL immediately force state IDLE and drive bus_req, wb_valid, wb_reg_write, misalign and stall to 0, with wb_data, wb_rd and bus_* data fields at 0.
- REQ-025 Reset during BUSY SHALL abandon the transaction; a late bus_ready after reset SHALL be ignored.

Configuration
- REQ-026 With MEM_ALIGN_CHECK_EN defined, a misaligned half (addr[0]=1) or word (addr[1:0]!=0) op SHALL issue no bus_req and SHALL, on the next edge, pulse misalign=1 and wb_valid=1 with wb_reg_write=0.
- REQ-027 Without MEM_ALIGN_CHECK_EN, misalign SHALL be tied to 0 and the address low bits SHALL be forced to 0 per size (aligned down).

Structure
- REQ-028 The mem_size encoding, the FSM state enum and the byte-enable constants SHALL live in shared package mips_pkg.
- REQ-029 Load lane select and extension SHALL be a combinational sub-module, load_align.

Verification
- REQ-030 Test 1: ALU op alu_result=0x1234, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, with no bus_req.
- REQ-031 Test 2: lb signed at addr 0x103, bus_rdata=0x80FFFFFF, bus_ready after 3 BUSY cycles -> stall high for 3 cycles, then wb_data=0xFFFFFF80.
- REQ-032 Test 3: sh at 0x202 with data 0xABCD -> bus_be=1100, bus_wdata=0xABCDABCD, wb_reg_write=0.
- REQ-033 Test 4: lw at 0x005 with MEM_ALIGN_CHECK_EN -> misalign pulse and no bus_req; without the macro -> bus_addr=0x004.
- REQ-034 Test 5: rst_n low mid-BUSY, then bus_ready=1 -> no wb_valid, and state is IDLE.
- REQ-035 Test 6: back-to-back lw, lw with zero-wait bus_ready -> two wb_valid pulses exactly 2 cycles apart.
